// File: rtl/seg7_pkg.sv
// Seven-segment encoding shared by the display driver and the bus reader.
// Keeping the hex table here means encode and decode cannot drift apart.
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam int DIGITS_DEF = 4;

  // Active-high segment patterns, bit 0 = A ... bit 6 = G, indexed by nibble.
  localparam logic [6:0] HEX_PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [3:0] nib;
    logic       dp;
    logic       ok;
  } sample_t;

  function automatic logic [6:0] seg7_enc(input logic [3:0] nib);
    return HEX_PAT[nib];
  endfunction

endpackage

// File: rtl/seg_display_reader_if.sv
// Multiplexed 7-segment bus plus the reader's decoded-frame outputs.
interface seg_display_reader_if #(
  parameter int DIGITS = 4
);
  logic [DIGITS-1:0]   sel;
  logic [7:0]          seg;
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic                valid;
  logic                err;
  logic                stale;

  modport master (output sel, seg, input data, dp, valid, err, stale);
  modport slave  (input sel, seg, output data, dp, valid, err, stale);
endinterface

// File: rtl/seg7_decode.sv
// Combinational inverse of the hex segment table; ok=0 for any pattern not in it.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] nib,
  output logic       ok
);
  always_comb begin
    nib = '0;
    ok  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pat == HEX_PAT[i]) begin
        nib = 4'(i);
        ok  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/seg_display_reader.sv
// Passive monitor of a multiplexed 7-segment bus: samples each digit once per
// settled dwell, rebuilds the displayed hex value and publishes whole frames.
module seg_display_reader
  import seg7_pkg::*;
#(
  parameter int DIGITS         = DIGITS_DEF,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input logic                 clk,
  input logic                 rst,
  seg_display_reader_if.slave bus
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef logic [DIGITS-1:0] dmask_t;

  dmask_t                  sel_q;
  logic [7:0]              stab_cnt;
  logic                    legal, same, sample, full, pub_ok;
  logic [IW-1:0]           idx;
  dmask_t                  onehot;
  logic [6:0]              pat;
  sample_t                 cur;

  logic [DIGITS-1:0][3:0]  sh_nib, frm_nib;
  dmask_t                  sh_dp, frm_dp, mask;
  logic                    err_flag;

  logic [DIGITS-1:0][3:0]  data_q;
  dmask_t                  dp_q;
  logic                    valid_q, err_q;
  logic [TW-1:0]           tcnt;

  // sel classification on the raw inputs
  assign onehot = ~bus.sel;
  assign legal  = ($countones(onehot) == 1);
  assign same   = (bus.sel == sel_q);

  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (!bus.sel[i]) idx = IW'(i);
  end

  // Counter value STABLE_CYCLES-2 here means it becomes STABLE_CYCLES-1 on this
  // edge; that single crossing is the one sample of the dwell.
  assign sample = legal && same && (stab_cnt == 8'(STABLE_CYCLES - 2));

  assign pat = ~bus.seg[SEG_G:SEG_A];

  seg7_decode u_dec (
    .pat (pat),
    .nib (cur.nib),
    .ok  (cur.ok)
  );
  assign cur.dp = ~bus.seg[SEG_DP];

  assign full   = &(mask | onehot);
  assign pub_ok = sample && full && !err_flag && cur.ok;

  // Frame as it will look once the current sample lands in its slot.
  always_comb begin
    frm_nib      = sh_nib;
    frm_dp       = sh_dp;
    frm_nib[idx] = cur.nib;
    frm_dp[idx]  = cur.dp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= '1;
      stab_cnt <= '0;
    end else begin
      sel_q <= bus.sel;
      if (!legal || !same)
        stab_cnt <= '0;
      else if (stab_cnt != 8'(STABLE_CYCLES))
        stab_cnt <= stab_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_nib   <= '0;
      sh_dp    <= '0;
      mask     <= '0;
      err_flag <= 1'b0;
      data_q   <= '0;
      dp_q     <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (sample) begin
        sh_nib[idx] <= cur.nib;
        sh_dp[idx]  <= cur.dp;
        if (full) begin
          mask     <= '0;
          err_flag <= 1'b0;
          if (err_flag || !cur.ok) begin
            err_q <= 1'b1;
          end else begin
            data_q  <= frm_nib;
            dp_q    <= frm_dp;
            valid_q <= 1'b1;
          end
        end else begin
          mask <= mask | onehot;
          if (!cur.ok) err_flag <= 1'b1;
        end
      end
    end
  end

  // Only a clean publish refreshes the watchdog; it wins over saturation.
  always_ff @(posedge clk) begin
    if (rst || pub_ok)
      tcnt <= '0;
    else if (tcnt != TW'(TIMEOUT_CYCLES))
      tcnt <= tcnt + TW'(1);
  end

  assign bus.data  = data_q;
  assign bus.dp    = dp_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;
  assign bus.stale = (tcnt == TW'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_seg_display_reader.sv
// Directed and randomized checks of seg_display_reader against a frame-level model.
module tb_seg_display_reader;
  localparam int S = 16;
  localparam int T = 1000;

  localparam logic [6:0] PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  localparam logic [6:0] BAD [4] = '{7'h00, 7'h01, 7'h7E, 7'h40};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_display_reader_if #(.DIGITS(4)) bus ();

  seg_display_reader #(
    .DIGITS(4), .STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0, miscompares = 0;
  int cyc = 0, vcnt = 0, ecnt = 0, last_vcyc = -1, last_start = 0;
  bit prev_stale = 1'b0, stale_before = 1'b0, stale_at_valid = 1'b0;

  // frame-level reference model
  logic [3:0]  m_nib [4];
  bit          m_dp  [4];
  bit [3:0]    m_mask = '0;
  bit          m_bad  = 1'b0;
  logic [15:0] e_data = '0;
  logic [3:0]  e_dp   = '0;
  int          e_v = 0, e_e = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      vcnt++;
      last_vcyc      = cyc;
      stale_before   = prev_stale;
      stale_at_valid = bus.stale;
    end
    if (bus.err === 1'b1) ecnt++;
    prev_stale = bus.stale;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".vcnt"}, vcnt, e_v);
    chk({tag, ".ecnt"}, ecnt, e_e);
    chk({tag, ".data"}, 32'(bus.data), 32'(e_data));
    chk({tag, ".dp"},   32'(bus.dp),   32'(e_dp));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] enc(input int n, input bit dpb);
    logic [6:0] p;
    p = PAT[n];
    return ~{dpb, p};
  endfunction

  task automatic blank(input int n);
    bus.sel = 4'b1111;
    bus.seg = 8'($urandom);
    cycles(n);
  endtask

  task automatic glitch(input int n);
    logic [3:0] s;
    do s = 4'($urandom); while ($countones(~s) < 2);
    bus.sel = s;
    bus.seg = 8'($urandom);
    cycles(n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(1);
    rst    = 1'b0;
    m_mask = '0;
    m_bad  = 1'b0;
    e_data = '0;
    e_dp   = '0;
  endtask

  // Show digit i with raw seg for dwell cycles; a dwell of S or more is one sample.
  task automatic show(input int i, input logic [7:0] raw, input int dwell);
    logic [6:0] p;
    int n;
    bus.sel    = ~(4'b0001 << i);
    bus.seg    = raw;
    last_start = cyc;
    cycles(dwell);
    if (dwell >= S) begin
      p = ~raw[6:0];
      n = -1;
      for (int k = 0; k < 16; k++) if (PAT[k] == p) n = k;
      m_nib[i] = 4'(n);
      m_dp[i]  = ~raw[7];
      if (n < 0) m_bad = 1'b1;
      m_mask[i] = 1'b1;
      if (&m_mask) begin
        if (m_bad) e_e++;
        else begin
          e_v++;
          e_data = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
          e_dp   = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
        end
        m_mask = '0;
        m_bad  = 1'b0;
      end
    end
  endtask

  task automatic wait_cyc(input int target);
    int k;
    k = 0;
    while (cyc != target && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("wait_cyc.reached", cyc, target);
  endtask

  initial begin
    int v0, i, dw, tgt;
    logic [7:0] raw;

    rst     = 1'b1;
    bus.sel = 4'b1111;
    bus.seg = 8'hFF;
    cycles(3);
    chk("rst.data",  32'(bus.data),  0);
    chk("rst.dp",    32'(bus.dp),    0);
    chk("rst.valid", 32'(bus.valid), 0);
    chk("rst.err",   32'(bus.err),   0);
    chk("rst.stale", 32'(bus.stale), 0);
    rst = 1'b0;

    // clean scan 0x1234, long dwells
    blank(20); show(0, enc(4, 0), 1000);
    blank(20); show(1, enc(3, 0), 1000);
    blank(20); show(2, enc(2, 0), 1000);
    blank(20); show(3, enc(1, 0), 1000);
    chk("clean.vcnt", vcnt, 1);
    chk("clean.data", 32'(bus.data), 32'h1234);
    chk("clean.dp",   32'(bus.dp),   0);
    chk("clean.ecnt", ecnt, 0);
    chk("clean.latency", last_vcyc, last_start + S);
    check_state("clean");

    // illegal segment pattern on digit 1, then clean 0xABCD
    blank(5); show(0, enc(4, 0), 40);
    blank(5); show(1, 8'hFF, 40);
    blank(5); show(2, enc(2, 0), 40);
    blank(5); show(3, enc(1, 0), 40);
    chk("illegal.ecnt", ecnt, 1);
    chk("illegal.vcnt", vcnt, 1);
    chk("illegal.data", 32'(bus.data), 32'h1234);
    blank(5); show(0, enc(13, 0), 40);
    blank(5); show(1, enc(12, 0), 40);
    blank(5); show(2, enc(11, 0), 40);
    blank(5); show(3, enc(10, 0), 40);
    chk("abcd.data", 32'(bus.data), 32'hABCD);
    chk("abcd.vcnt", vcnt, 2);
    check_state("abcd");

    // short dwell on digit 2 must not count
    blank(5); show(2, enc(5, 0), S - 2);
    blank(5); show(0, enc(6, 0), 40);
    blank(5); show(1, enc(7, 0), 40);
    blank(5); show(3, enc(8, 0), 40);
    chk("short.vcnt", vcnt, 2);
    blank(5); show(2, enc(9, 0), S + 4);
    chk("short.data", 32'(bus.data), 32'h8976);
    chk("short.vcnt2", vcnt, 3);

    // multi-low sel mid-scan; DP lit on digit 3
    blank(5); show(0, enc(1, 0), 40);
    blank(5); show(1, enc(2, 0), 40);
    bus.sel = 4'b1100; bus.seg = 8'h00; cycles(50);
    blank(5); show(2, enc(3, 0), 40);
    blank(5); show(3, enc(4, 1), 40);
    chk("glitch.data", 32'(bus.data), 32'h4321);
    chk("glitch.dp",   32'(bus.dp),   32'b1000);
    chk("glitch.ecnt", ecnt, 1);
    chk("glitch.vcnt", vcnt, 4);

    // watchdog: stale exactly T cycles after the publish edge
    tgt = last_vcyc + T - 1;
    bus.sel = 4'b1111;
    wait_cyc(tgt);
    chk("timeout.before", 32'(bus.stale), 0);
    wait_cyc(tgt + 1);
    chk("timeout.at", 32'(bus.stale), 1);
    @(posedge clk); #1;
    blank(5);
    chk("timeout.held", 32'(bus.stale), 1);
    show(0, enc(5, 0), 30); blank(3);
    show(1, enc(6, 0), 30); blank(3);
    show(2, enc(7, 0), 30); blank(3);
    show(3, enc(8, 0), 30);
    chk("resume.stale_before", 32'(stale_before), 1);
    chk("resume.stale_at_valid", 32'(stale_at_valid), 0);
    chk("resume.data", 32'(bus.data), 32'h8765);
    check_state("resume");

    // randomized scans, any order, mixed dwells and bad patterns
    for (int it = 0; it < 160; it++) begin
      if ($urandom_range(0, 5) == 0) glitch($urandom_range(1, 30));
      blank($urandom_range(1, 4));
      i = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) raw = {1'b1, ~BAD[$urandom_range(0, 3)]};
      else raw = enc($urandom_range(0, 15), 1'($urandom_range(0, 1)));
      dw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, S - 2) : $urandom_range(S + 2, S + 40);
      show(i, raw, dw);
      check_state("rand");
    end

    // reset mid-frame discards partial captures
    do_reset();
    v0 = vcnt;
    blank(3); show(0, enc(1, 0), 30);
    blank(3); show(1, enc(2, 0), 30);
    do_reset();
    chk("midrst.data",  32'(bus.data),  0);
    chk("midrst.dp",    32'(bus.dp),    0);
    chk("midrst.valid", 32'(bus.valid), 0);
    chk("midrst.err",   32'(bus.err),   0);
    chk("midrst.stale", 32'(bus.stale), 0);
    blank(3); show(2, enc(3, 0), 30);
    blank(3); show(3, enc(4, 0), 30);
    blank(5);
    chk("midrst.novalid", vcnt, v0);
    check_state("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_display_reader.md
Name: seg_display_reader

Overview:
- Passive monitor for the 4-digit multiplexed 7-segment bus (active-LOW digit selects, active-LOW segments).
- Samples each digit after its select has settled and decodes the segment pattern back to a hex nibble.
- Assembles the four nibbles into the 16-bit value on screen.
- Used for on-board loopback self-check of the display driver, and as a bench checker for display labs.

Parameters:
- DIGITS, 4, number of multiplexed digits (width of sel; data width = 4*DIGITS)
- STABLE_CYCLES, 16, consecutive clk cycles sel must hold a legal one-cold value before seg is sampled; range 2..255
- TIMEOUT_CYCLES, 1048576, clk cycles without a published frame before stale asserts

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  synchronous reset, active-high
- sel  in  DIGITS  digit selects, active LOW; bit i low selects digit i (digit 0 = least significant nibble)
- seg  in  8  segment lines, active LOW; bits 0..6 = segments A..G, bit 7 = DP
- data  out  4*DIGITS  last complete decoded frame
- dp  out  DIGITS  radix-point state per digit, from the same frame as data (1 = lit)
- valid  out  1  one-cycle pulse when data/dp update
- err  out  1  one-cycle pulse when a frame is discarded for an illegal pattern
- stale  out  1  level; no frame published for TIMEOUT_CYCLES

Behaviour:
- Reset: data=0, dp=0, valid=0, err=0, stale=0; stable counter, capture mask, error flag and timeout counter all cleared.
- Reset applies even mid-frame: partial captures are discarded.
- sel classification, applied to the raw inputs each cycle:
  - legal: exactly one bit low.
  - blank: all bits high.
  - illegal: more than one bit low.
- Stable counter:
  - Clears whenever sel differs from its previous-cycle value, or is blank or illegal.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Sample event: the cycle the counter first reaches STABLE_CYCLES-1 with sel legal. Exactly one sample per dwell; a long dwell never resamples.
- Decode: invert seg, then match bits 6:0 against the hex set:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - Any other value, including all-off, is illegal.
- At each sample, write nibble and DP bit into shadow slot i and set mask bit i.
  - A slot resampled before the frame completes is overwritten with the newer value.
  - An illegal pattern sets the frame error flag and still sets mask bit i.
- Publish:
  - Trigger: the clock edge ending the sample cycle that completes the mask (all ones).
  - Clean frame: data/dp load from the shadow, with the final sample bypassed in, and valid=1 for the following cycle.
  - Error flag set: data/dp hold, err=1 for the following cycle.
  - In both cases the mask and error flag clear.
  - Latency: valid is high in the cycle after the last digit's sample cycle.
- Illegal sel (multiple low) does not corrupt a frame; it only resets the stable counter.
- Timeout counter:
  - Increments every cycle and saturates at TIMEOUT_CYCLES.
  - stale=1 while saturated.
  - A valid publish clears the counter and stale in the same edge; an err publish does not.
  - Publish and saturation in the same cycle: publish wins, stale stays 0.
- No assumption on scan order or scan rate; digits may arrive in any order.

Decomposition:
- Package seg7_pkg:
  - SEG_A..SEG_G and SEG_DP bit indices.
  - The 16-entry hex pattern constant array, shared with the display driver so encode and decode never diverge.
  - Default DIGITS.
- Sub-module seg7_decode: combinational, 7-bit active-high pattern in, 4-bit nibble out, 1-bit ok out.
- Top level holds the stable counter, sel classifier, shadow/mask, publish logic and timeout.

Test Plan:
- Clean scan: drive digits 0..3 with patterns for 4,3,2,1 (DP off), 1000-cycle dwells and 20-cycle blanks between -> one valid pulse, data=0x1234, dp=0, err stays 0.
- Short dwell: digit 2 selected for only STABLE_CYCLES-2 cycles, then others complete -> no valid until digit 2 later dwells >= STABLE_CYCLES; data reflects the later value.
- Illegal pattern: digit 1 shows raw active-high 0x00 (blank) in one frame -> err pulse, data holds previous 0x1234, next clean frame 0xABCD -> valid, data=0xABCD.
- Glitch sel: sel=4'b1100 for 50 cycles mid-scan -> no sample and no err; frame still publishes correctly. DP on digit 3 -> dp=4'b1000.
- Timeout: TIMEOUT_CYCLES=1000, stop scanning after one frame -> stale=1 at cycle 1000 after the publish; resume -> stale=0 on the valid cycle's edge.
- Reset mid-frame: capture digits 0,1, assert rst one cycle, then capture only digits 2,3 -> no valid; all outputs 0 after reset.
